// File: rtl/conv_pkg.sv
// Shared types for the convolution operand path: FSM states, loop-index type
// and the padding width derived from the kernel size.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef logic signed [31:0] idx_t;

    function automatic idx_t pad_of(input int kernel_size);
        return idx_t'((kernel_size - 1) / 2);
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Four-entry response FIFO: unconditional push side, valid/ready pop side.
// The producer guarantees it never pushes into a full FIFO.
module stream_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [2:0]       count_o
);
    localparam int DEPTH = 4;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [2:0]       count_q;
    logic [2:0]       count_d;
    logic             pop;

    assign pop_valid_o = (count_q != 3'd0);
    assign pop         = pop_valid_o && pop_ready_i;
    assign pop_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop) begin
            count_d = count_q + 3'd1;
        end else if (!push_i && pop) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/operand_streamer.sv
// Walks x/y/ch_in/ch_out/k_v/k_h, reads activation and kernel SRAMs and streams
// (a, b) operand pairs, substituting zero activations in the padding border.
module operand_streamer
    import conv_pkg::*;
#(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int DATA_WIDTH         = 16
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          act_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] act_addr,
    input  logic [DATA_WIDTH-1:0]         act_rdata,
    output logic                          krn_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] krn_addr,
    input  logic [DATA_WIDTH-1:0]         krn_rdata,
    output logic [DATA_WIDTH-1:0]         a_out,
    output logic [DATA_WIDTH-1:0]         b_out,
    output logic                          a_valid,
    output logic                          b_valid,
    input  logic                          a_ready,
    input  logic                          b_ready
);
    typedef logic [LOG2_OF_MEM_HEIGHT-1:0] addr_t;

    localparam idx_t PAD  = pad_of(KERNEL_SIZE);
    localparam idx_t W    = idx_t'(FEATURE_MAP_WIDTH);
    localparam idx_t H    = idx_t'(FEATURE_MAP_HEIGHT);
    localparam idx_t CIN  = idx_t'(INPUT_NB_CHANNELS);
    localparam idx_t COUT = idx_t'(OUTPUT_NB_CHANNELS);
    localparam idx_t K    = idx_t'(KERNEL_SIZE);

    // Counter slots, innermost first: k_h wraps into k_v, ..., y wraps into x.
    localparam int NCNT = 6;
    localparam int C_KH = 0, C_KV = 1, C_CO = 2, C_CI = 3, C_Y = 4, C_X = 5;
    localparam idx_t LIMIT [NCNT] = '{K - 1, K - 1, COUT - 1, CIN - 1, H - 1, W - 1};

    state_e            state_q, state_d;
    idx_t              cnt_q [NCNT];
    logic [NCNT-1:0]   at_max;
    logic [NCNT-1:0]   carry;
    logic              last_idx;
    logic              issue, clear_cnt, credit_ok;
    logic              inflight_q, pad_q, done_q, done_d;
    idx_t              row, col, act_full, krn_full;
    logic              pad_hit;
    logic [2:0]        fifo_count, credit_sum;
    logic              fifo_valid, pop;
    logic [2*DATA_WIDTH-1:0] push_data, pop_data;

    always_comb begin
        at_max   = '0;
        carry    = '0;
        carry[0] = issue;
        for (int k = 0; k < NCNT; k++) begin
            at_max[k] = (cnt_q[k] == LIMIT[k]);
        end
        for (int k = 0; k < NCNT - 1; k++) begin
            carry[k+1] = carry[k] && at_max[k];
        end
    end

    assign last_idx = &at_max;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
        end else if (clear_cnt) begin
            for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                if (carry[k]) cnt_q[k] <= at_max[k] ? '0 : cnt_q[k] + idx_t'(1);
            end
        end
    end

    assign row      = cnt_q[C_Y] + cnt_q[C_KV] - PAD;
    assign col      = cnt_q[C_X] + cnt_q[C_KH] - PAD;
    assign pad_hit  = (row < 0) || (row >= H) || (col < 0) || (col >= W);
    assign act_full = (row * W + col) * CIN + cnt_q[C_CI];
    assign krn_full = ((cnt_q[C_KV] * K + cnt_q[C_KH]) * CIN + cnt_q[C_CI]) * COUT + cnt_q[C_CO];

    // Credit uses only registered occupancy, so ready never reaches the SRAM enables.
    assign credit_sum = fifo_count + {2'b00, inflight_q};
    assign credit_ok  = (credit_sum < 3'd3);

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        clear_cnt = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ISSUE;
                    clear_cnt = 1'b1;
                end
            end
            ST_ISSUE: begin
                issue = credit_ok;
                if (credit_ok && last_idx) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight_q && (fifo_count == 3'd0 || (fifo_count == 3'd1 && pop))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            pad_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            pad_q      <= issue && pad_hit;
            done_q     <= done_d;
        end
    end

    assign act_re   = issue && !pad_hit;
    assign act_addr = act_re ? addr_t'(act_full) : '0;
    assign krn_re   = issue;
    assign krn_addr = issue ? addr_t'(krn_full) : '0;

    assign push_data = {(pad_q ? {DATA_WIDTH{1'b0}} : act_rdata), krn_rdata};

    stream_fifo #(
        .WIDTH(2 * DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .arst_n_in   (arst_n_in),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_valid_o (fifo_valid),
        .pop_ready_i (a_ready && b_ready),
        .pop_data_o  (pop_data),
        .count_o     (fifo_count)
    );

    assign pop     = fifo_valid && a_ready && b_ready;
    assign a_valid = fifo_valid;
    assign b_valid = fifo_valid;
    assign a_out   = pop_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign b_out   = pop_data[DATA_WIDTH-1:0];
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_operand_streamer.sv
// Scenario bench for operand_streamer: a 3x3 padded layer and a 1x1 multi-channel layer.
module tb_operand_streamer;

    logic clk, arst_n_in;
    logic start, busy, done, act_re, krn_re, a_valid, b_valid, a_ready, b_ready;
    logic [7:0]  act_addr, krn_addr;
    logic [15:0] act_rdata, krn_rdata, a_out, b_out;

    logic start_k, busy_k, done_k, act_re_k, krn_re_k, a_valid_k, b_valid_k, ready_k;
    logic [7:0]  act_addr_k, krn_addr_k;
    logic [15:0] act_rdata_k, krn_rdata_k, a_out_k, b_out_k;

    logic [15:0] act_mem [256];
    logic [15:0] krn_mem [256];

    logic [31:0] exp_q [$];
    logic [31:0] exp_k [$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, t0 = 0;
    int xfer_cnt, issue_cnt, done_cnt, first_re_cyc, first_valid_cyc, done_cyc;
    logic [31:0] first_pair, pair4;
    logic hold_pending = 1'b0;
    logic [15:0] held_a, held_b;

    operand_streamer #(
        .LOG2_OF_MEM_HEIGHT(8), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
        .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(3), .DATA_WIDTH(16)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .busy(busy), .done(done),
        .act_re(act_re), .act_addr(act_addr), .act_rdata(act_rdata),
        .krn_re(krn_re), .krn_addr(krn_addr), .krn_rdata(krn_rdata),
        .a_out(a_out), .b_out(b_out), .a_valid(a_valid), .b_valid(b_valid),
        .a_ready(a_ready), .b_ready(b_ready)
    );

    operand_streamer #(
        .LOG2_OF_MEM_HEIGHT(8), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
        .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1), .DATA_WIDTH(16)
    ) dut_k1 (
        .clk(clk), .arst_n_in(arst_n_in), .start(start_k), .busy(busy_k), .done(done_k),
        .act_re(act_re_k), .act_addr(act_addr_k), .act_rdata(act_rdata_k),
        .krn_re(krn_re_k), .krn_addr(krn_addr_k), .krn_rdata(krn_rdata_k),
        .a_out(a_out_k), .b_out(b_out_k), .a_valid(a_valid_k), .b_valid(b_valid_k),
        .a_ready(ready_k), .b_ready(ready_k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models with one-cycle read latency
    always @(posedge clk) begin
        if (act_re)   act_rdata   <= act_mem[act_addr];
        if (krn_re)   krn_rdata   <= krn_mem[krn_addr];
        if (act_re_k) act_rdata_k <= act_mem[act_addr_k];
        if (krn_re_k) krn_rdata_k <= krn_mem[krn_addr_k];
    end

    // Expected pair stream in loop order x, y, ch_in, ch_out, k_v, k_h
    task automatic push_layer(input int w, input int h, input int cin, input int cout,
                              input int k, input bit to_k1);
        int pad, row, col, a, b;
        pad = (k - 1) / 2;
        for (int x = 0; x < w; x++)
            for (int y = 0; y < h; y++)
                for (int ci = 0; ci < cin; ci++)
                    for (int co = 0; co < cout; co++)
                        for (int kv = 0; kv < k; kv++)
                            for (int kh = 0; kh < k; kh++) begin
                                row = y + kv - pad;
                                col = x + kh - pad;
                                a = 0;
                                if (row >= 0 && row < h && col >= 0 && col < w)
                                    a = (row * w + col) * cin + ci + 1;
                                b = 10 + ((kv * k + kh) * cin + ci) * cout + co;
                                if (to_k1) exp_k.push_back({16'(a), 16'(b)});
                                else       exp_q.push_back({16'(a), 16'(b)});
                            end
    endtask

    // Scoreboard monitor for the 3x3 instance, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!arst_n_in) begin
                hold_pending = 1'b0;
            end else begin
                n_checks++;
                if (b_valid !== a_valid) begin
                    n_fail++;
                    $display("FAIL b_valid_eq: b_valid=%b a_valid=%b", b_valid, a_valid);
                end
                if (act_re || krn_re) begin
                    n_checks++;
                    if (!krn_re || (issue_cnt - xfer_cnt) >= 3) begin
                        n_fail++;
                        $display("FAIL credit: read with outstanding=%0d krn_re=%b, need <3 and krn_re=1",
                                 issue_cnt - xfer_cnt, krn_re);
                    end
                end
                if (hold_pending) begin
                    n_checks++;
                    if (a_valid !== 1'b1 || a_out !== held_a || b_out !== held_b) begin
                        n_fail++;
                        $display("FAIL hold: valid=%b a=%0d b=%0d, need valid=1 a=%0d b=%0d",
                                 a_valid, a_out, b_out, held_a, held_b);
                    end
                end
                if (a_valid && a_ready && b_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_pair: a=%0d b=%0d, none expected", a_out, b_out);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        if ({a_out, b_out} !== e) begin
                            n_fail++;
                            $display("FAIL pair[%0d]: a=%0d b=%0d, want a=%0d b=%0d",
                                     xfer_cnt, a_out, b_out, e[31:16], e[15:0]);
                        end
                    end
                    if (xfer_cnt == 0) first_pair = {a_out, b_out};
                    if (xfer_cnt == 4) pair4 = {a_out, b_out};
                    xfer_cnt++;
                    hold_pending = 1'b0;
                end else begin
                    hold_pending = a_valid;
                    held_a = a_out;
                    held_b = b_out;
                end
                if (krn_re) begin
                    if (first_re_cyc < 0) first_re_cyc = cyc;
                    issue_cnt++;
                end
                if (a_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic start_layer();
        start = 1'b1;
        t0 = cyc;
        xfer_cnt = 0; issue_cnt = 0; done_cnt = 0;
        first_re_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
        push_layer(2, 2, 1, 1, 3, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs until done, driving ready (fixed or random with one b-only stall) and an optional stray start
    task automatic wait_done(input int budget, input bit rand_ready, input int pulse_at, output bit ok);
        int stall_left;
        bit stall_used;
        ok = 1'b0; stall_left = 0; stall_used = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            start = (pulse_at >= 0) && (cyc - t0 == pulse_at);
            if (!rand_ready) begin
                a_ready = 1'b1; b_ready = 1'b1;
            end else if (stall_left > 0) begin
                a_ready = 1'b1; b_ready = 1'b0; stall_left--;
            end else if (!stall_used && a_valid && xfer_cnt >= 5) begin
                a_ready = 1'b1; b_ready = 1'b0; stall_used = 1'b1; stall_left = 4;
            end else begin
                a_ready = ($urandom_range(0, 3) != 0);
                b_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        arst_n_in = 1'b0; start = 1'b0; start_k = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; ready_k = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, a_valid, b_valid, act_re, krn_re} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/av/bv/are/kre=%b, want 000000",
                     {busy, done, a_valid, b_valid, act_re, krn_re});
        end
        n_checks++;
        if ({a_out, b_out, act_addr, krn_addr} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_data: a=%0d b=%0d aa=%0d ka=%0d, want all 0", a_out, b_out, act_addr, krn_addr);
        end
        arst_n_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        bit ok;
        start_layer();
        wait_done(200, 1'b0, -1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stream_timeout: no done, want done within 200 cycles"); end
        n_checks++;
        if (xfer_cnt != 36) begin n_fail++; $display("FAIL stream_count: %0d transfers, want 36", xfer_cnt); end
        n_checks++;
        if (first_re_cyc - t0 != 1) begin n_fail++; $display("FAIL first_re: T+%0d, want T+1", first_re_cyc - t0); end
        n_checks++;
        if (first_valid_cyc - t0 != 3) begin n_fail++; $display("FAIL first_valid: T+%0d, want T+3", first_valid_cyc - t0); end
        n_checks++;
        if (done_cyc - t0 != 39) begin n_fail++; $display("FAIL done_cycle: T+%0d, want T+39", done_cyc - t0); end
        n_checks++;
        if (first_pair !== 32'h0000_000a) begin
            n_fail++; $display("FAIL first_pair: a=%0d b=%0d, want a=0 b=10", first_pair[31:16], first_pair[15:0]);
        end
        n_checks++;
        if (pair4 !== 32'h0001_000e) begin
            n_fail++; $display("FAIL pair5: a=%0d b=%0d, want a=1 b=14", pair4[31:16], pair4[15:0]);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stream_end: busy=%b done=%b left=%0d, want 0 1 0", busy, done, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_layer();
        wait_done(200, 1'b0, -1, ok);
        n_checks++;
        if (!ok || xfer_cnt != 36 || first_re_cyc - t0 != 1) begin
            n_fail++;
            $display("FAIL back_to_back: ok=%b transfers=%0d first_re=T+%0d, want 1 36 T+1", ok, xfer_cnt, first_re_cyc - t0);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        @(posedge clk); #1;
        start_layer();
        wait_done(800, 1'b1, -1, ok);
        n_checks++;
        if (!ok || xfer_cnt != 36 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_ready: ok=%b transfers=%0d left=%0d, want 1 36 0", ok, xfer_cnt, exp_q.size());
        end
        a_ready = 1'b1; b_ready = 1'b1;
    endtask

    task automatic test_start_ignored();
        bit ok;
        @(posedge clk); #1;
        start_layer();
        wait_done(200, 1'b0, 10, ok);
        repeat (6) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (!ok || xfer_cnt != 36 || done_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: ok=%b transfers=%0d dones=%0d busy=%b, want 1 36 1 0",
                     ok, xfer_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        @(posedge clk); #1;
        start_layer();
        for (int i = 0; i < 100 && xfer_cnt < 12; i++) begin
            @(negedge clk); #1;
        end
        arst_n_in = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, a_valid, b_valid, act_re, krn_re, a_out, b_out, act_addr, krn_addr} !== 54'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b av=%b a=%0d b=%0d re=%b, want all 0", busy, a_valid, a_out, b_out, krn_re);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        arst_n_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_done: dones=%0d busy=%b, want 0 0", done_cnt, busy);
        end
        start_layer();
        wait_done(200, 1'b0, -1, ok);
        n_checks++;
        if (!ok || xfer_cnt != 36 || first_pair !== 32'h0000_000a) begin
            n_fail++;
            $display("FAIL restart: ok=%b transfers=%0d first a=%0d b=%0d, want 1 36 a=0 b=10",
                     ok, xfer_cnt, first_pair[31:16], first_pair[15:0]);
        end
    endtask

    task automatic test_k1();
        int n;
        bit seen_done;
        logic [31:0] e;
        n = 0; seen_done = 1'b0;
        push_layer(2, 2, 2, 2, 1, 1'b1);
        @(posedge clk); #1;
        start_k = 1'b1;
        @(posedge clk); #1;
        start_k = 1'b0;
        for (int i = 0; i < 200 && !seen_done; i++) begin
            @(negedge clk);
            if (krn_re_k) begin
                n_checks++;
                if (act_re_k !== 1'b1) begin n_fail++; $display("FAIL k1_act_re: act_re=%b, want 1", act_re_k); end
            end
            if (a_valid_k) begin
                e = (exp_k.size() != 0) ? exp_k.pop_front() : 32'hffff_ffff;
                n_checks++;
                if ({a_out_k, b_out_k} !== e) begin
                    n_fail++;
                    $display("FAIL k1_pair[%0d]: a=%0d b=%0d, want a=%0d b=%0d", n, a_out_k, b_out_k, e[31:16], e[15:0]);
                end
                n_checks++;
                if ((int'(b_out_k) - 10) % 2 != n % 2) begin
                    n_fail++; $display("FAIL k1_ch_out[%0d]: ch_out=%0d, want %0d", n, (int'(b_out_k) - 10) % 2, n % 2);
                end
                n++;
            end
            if (done_k) seen_done = 1'b1;
        end
        n_checks++;
        if (!seen_done || n != 16 || exp_k.size() != 0) begin
            n_fail++; $display("FAIL k1_count: done=%b transfers=%0d left=%0d, want 1 16 0", seen_done, n, exp_k.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = 16'(i + 1);
            krn_mem[i] = 16'(10 + i);
        end
        xfer_cnt = 0; issue_cnt = 0; done_cnt = 0;
        first_re_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
        test_reset();
        test_stream();
        test_back_to_back();
        test_random_ready();
        test_start_ignored();
        test_reset_abort();
        test_k1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
